// File: rtl/dma_mem_bank.sv
// Shared-bus test memory: address/data phases under MEMW/MEMR, arbiter handshake
// before driving read data, programmable wait states and burst auto-increment.
module dma_mem_bank #(
  parameter int         DATA_W      = 8,
  parameter int         BUS_W       = 16,
  parameter int         DEPTH       = 32,
  parameter int         WAIT_STATES = 1,
  parameter logic [1:0] DRV_AEN     = 2'd2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             memw,
  input  logic             memr,
  input  logic [1:0]       aen,
  inout  wire  [BUS_W-1:0] bus,
  output logic             ready,
  input  logic             gnt,
  output logic             req,
  input  logic             burst,
  output logic             err
);
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam bit POW2   = ((1 << ADDR_W) == DEPTH);

  typedef enum logic [2:0] {IDLE, W_DATA, R_REQ, R_WAIT, R_DATA} state_t;
  typedef logic [DEPTH-1:0][DATA_W-1:0] mem_t;

  function automatic mem_t mem_init();
    mem_t m;
    for (int i = 0; i < DEPTH; i++) m[i] = DATA_W'(i);
    return m;
  endfunction

  // Preloaded with each word's own index; reset deliberately leaves it alone.
  mem_t mem = mem_init();

  state_t            state, state_d;
  logic [ADDR_W-1:0] addr, addr_d, addr_inc;
  logic [DATA_W-1:0] rdata, rdata_d;
  logic [3:0]        wcnt, wcnt_d;
  logic              ready_d, req_d, err_d, we, bus_oor, inc_oor;

  assign addr_inc = addr + ADDR_W'(1);
  assign bus_oor  = (bus >= BUS_W'(DEPTH));
  // A non-power-of-two depth cannot wrap, so stepping past the top is an error
  assign inc_oor  = !POW2 && (addr == ADDR_W'(DEPTH - 1));
  assign bus      = (state == R_DATA && aen == DRV_AEN) ? BUS_W'(rdata) : {BUS_W{1'bz}};

  always_comb begin
    state_d = state;
    addr_d  = addr;
    rdata_d = rdata;
    wcnt_d  = wcnt;
    ready_d = ready;
    req_d   = req;
    err_d   = err;
    we      = 1'b0;
    case (state)
      IDLE: begin
        if (memw) begin
          addr_d  = bus[ADDR_W-1:0];
          err_d   = bus_oor;
          ready_d = 1'b1;
          state_d = W_DATA;
        end else if (memr) begin
          addr_d  = bus[ADDR_W-1:0];
          err_d   = bus_oor;
          req_d   = 1'b1;
          state_d = R_REQ;
        end
      end
      W_DATA: begin
        if (memw && burst) begin
          we     = !err;
          addr_d = addr_inc;
          if (inc_oor) err_d = 1'b1;
        end else begin
          we      = memw && !err;
          ready_d = 1'b0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      R_REQ: begin
        if (!memr) begin
          req_d   = 1'b0;
          err_d   = 1'b0;
          state_d = IDLE;
        end else if (gnt) begin
          rdata_d = err ? '0 : mem[addr];
          wcnt_d  = 4'(WAIT_STATES);
          if (WAIT_STATES == 0) begin
            ready_d = 1'b1;
            state_d = R_DATA;
          end else begin
            state_d = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        wcnt_d = wcnt - 4'd1;
        if (!memr) begin
          req_d   = 1'b0;
          err_d   = 1'b0;
          state_d = IDLE;
        end else if (!gnt) begin
          state_d = R_REQ;
        end else if (wcnt == 4'd1) begin
          ready_d = 1'b1;
          state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (memr && burst) begin
          addr_d = addr_inc;
          if (err || inc_oor) begin
            rdata_d = '0;
            err_d   = 1'b1;
          end else begin
            rdata_d = mem[addr_inc];
          end
        end else begin
          ready_d = 1'b0;
          req_d   = 1'b0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      addr  <= '0;
      rdata <= '0;
      wcnt  <= '0;
      ready <= 1'b0;
      req   <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_d;
      addr  <= addr_d;
      rdata <= rdata_d;
      wcnt  <= wcnt_d;
      ready <= ready_d;
      req   <= req_d;
      err   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= bus[DATA_W-1:0];
  end
endmodule
